// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: groups the instruction-memory read bus and the
// decoder issue handshake driven by instr_sequencer.
//   master : the sequencer (drives the read strobe/address and the issued instruction)
//   slave  : the memory/decoder side (returns read data and accepts instructions)
interface instr_sequencer_if #(
   parameter int PC_W = 8
) ();
   logic            imem_rd;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic [15:0]     instr;
   logic            instr_valid;
   logic            instr_ready;

   modport master (
      output imem_rd,
      output imem_addr,
      input  imem_rdata,
      output instr,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
      input  imem_rd,
      input  imem_addr,
      output imem_rdata,
      input  instr,
      input  instr_valid,
      output instr_ready
   );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/issue controller for the 16-bit opcode
// decoder. It fetches from a synchronous instruction memory, presents each
// instruction through a valid/ready handshake and advances the PC.
// It intercepts HALT (opcode 111) in every build. It intercepts JMP (opcode 110)
// only when the macro INSTR_SEQ_JUMP_EN is defined. Without that macro,
// opcode 110 is issued like any other instruction.
module instr_sequencer #(
   parameter int PC_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [PC_W-1:0]     start_addr,
   input  logic                stop,
   instr_sequencer_if.master   bus,
   output logic [PC_W-1:0]     pc,
   output logic                busy,
   output logic                halted,
   output logic [15:0]         retired
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_ISSUE,
      ST_HALTED
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t      state;
   state_t      state_nxt;
   logic [15:0] instr_q;
   logic        is_halt;
   logic        is_jump;
   logic        start_ok;

   // stop wins over start when both are asserted in the same cycle
   assign start_ok = start && !stop;
   assign is_halt  = (bus.imem_rdata[15:13] == 3'b111);
`ifdef INSTR_SEQ_JUMP_EN
   assign is_jump  = (bus.imem_rdata[15:13] == 3'b110);
`else
   assign is_jump  = 1'b0;
`endif

   assign bus.imem_addr = pc;
   assign bus.instr     = instr_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection: stop aborts every active state, and read data is classified in WAIT
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_nxt = stop ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (is_halt) begin
               state_nxt = ST_HALTED;
            end else if (is_jump) begin
               state_nxt = ST_FETCH;
            end else begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (bus.instr_ready) begin
               state_nxt = ST_FETCH;
            end
         end
         ST_HALTED: begin
            if (stop) begin
               state_nxt = ST_IDLE;
            end else if (start) begin
               state_nxt = ST_FETCH;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status and strobe outputs depend only on the registered state
   always_comb begin
      bus.imem_rd     = 1'b0;
      bus.instr_valid = 1'b0;
      busy            = 1'b0;
      halted          = 1'b0;
      case (state)
         ST_FETCH: begin
            bus.imem_rd = 1'b1;
            busy        = 1'b1;
         end
         ST_WAIT: begin
            busy = 1'b1;
         end
         ST_ISSUE: begin
            bus.instr_valid = 1'b1;
            busy            = 1'b1;
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Datapath: PC, the issued instruction and the saturating retired-instruction counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= '0;
         instr_q <= '0;
         retired <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALTED: begin
               if (start_ok) begin
                  pc      <= start_addr;
                  retired <= '0;
               end
            end
            ST_WAIT: begin
               if (!stop && !is_halt) begin
                  if (is_jump) begin
                     pc <= bus.imem_rdata[PC_W-1:0];
                  end else begin
                     instr_q <= bus.imem_rdata;
                  end
               end
            end
            ST_ISSUE: begin
               if (bus.instr_ready) begin
                  pc <= pc + PC_ONE;
                  if (retired != 16'hFFFF) begin
                     retired <= retired + 16'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: self-checking bench for instr_sequencer.
// The reference is a program walker. It follows the instruction memory from a
// start address and applies the HALT and JMP rules. It lists the instructions
// that must be issued, with the PC of each, and the final PC.
// A single negedge process checks every handshake against that list. The same
// process tracks the retired count and the hold-while-stalled rules.
module tb_instr_sequencer;

   localparam int PC_W = 8;

   typedef struct {
      logic [15:0] ins;
      logic [7:0]  addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  start_addr;
   logic        stop;
   logic [7:0]  pc;
   logic        busy;
   logic        halted;
   logic [15:0] retired;

   logic [15:0] mem [256];

   exp_t        exp_q[$];
   exp_t        e_cur;
   logic [15:0] iss_log[$];
   int          iss_cyc[$];
   int          checks = 0;
   int          errors = 0;
   int          ncyc = 0;
   int          start_ncyc = 0;
   int          model_retired = 0;
   bit          chk_en = 1'b0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_instr;
   logic [7:0]  prev_pc;

   instr_sequencer_if #(.PC_W(PC_W)) bus ();

   instr_sequencer #(.PC_W(PC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .stop       (stop),
      .bus        (bus),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted),
      .retired    (retired)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Synchronous instruction memory: read data appears the cycle after the strobe
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.imem_rdata <= 16'h0000;
      end else if (bus.imem_rd) begin
         bus.imem_rdata <= mem[bus.imem_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [7:0] a, input logic st, input logic rdy);
      start           = s;
      start_addr      = a;
      stop            = st;
      bus.instr_ready = rdy;
   endtask

   // Walk the program and append the instructions that must issue to exp_q.
   // The walk succeeds only if it reaches a HALT within its step budget.
   task automatic modelRun(input logic [7:0] sa, output bit ok, output logic [7:0] fpc, output int n_iss);
      exp_t        loc[$];
      logic [7:0]  p;
      logic [15:0] w;
      p     = sa;
      ok    = 1'b0;
      n_iss = 0;
      for (int step = 0; step < 64 && !ok; step++) begin
         w = mem[p];
         if (w[15:13] == 3'b111) begin
            ok = 1'b1;
         end
`ifdef INSTR_SEQ_JUMP_EN
         else if (w[15:13] == 3'b110) begin
            p = w[7:0];
         end
`endif
         else begin
            loc.push_back('{ins: w, addr: p});
            p = p + 8'd1;
         end
      end
      fpc   = p;
      n_iss = loc.size();
      if (ok) begin
         foreach (loc[i]) exp_q.push_back(loc[i]);
      end
   endtask

   task automatic startAt(input logic [7:0] a, input logic rdy);
      applyStimulus(1'b1, a, 1'b0, rdy);
      @(posedge clk);
      #1;
      start         = 1'b0;
      model_retired = 0;
      start_ncyc    = ncyc;
   endtask

   task automatic runUntilHalt(input int maxc, input bit rand_ready, output int n);
      n = 0;
      while (!halted && n < maxc) begin
         if (rand_ready) bus.instr_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
         n++;
      end
      bus.instr_ready = 1'b0;
      checkOutput("halt_reached", 32'(halted), 32'd1);
   endtask

   task automatic waitValid(input int maxc);
      int n;
      n = 0;
      while (!bus.instr_valid && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("valid_seen", 32'(bus.instr_valid), 32'd1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pc"},        32'(pc), 32'd0);
      checkOutput({tag, "_instr"},     32'(bus.instr), 32'd0);
      checkOutput({tag, "_retired"},   32'(retired), 32'd0);
      checkOutput({tag, "_imem_rd"},   32'(bus.imem_rd), 32'd0);
      checkOutput({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
      checkOutput({tag, "_valid"},     32'(bus.instr_valid), 32'd0);
      checkOutput({tag, "_busy"},      32'(busy), 32'd0);
      checkOutput({tag, "_halted"},    32'(halted), 32'd0);
   endtask

   // Per-cycle compare against the walker's issue list and the handshake rules
   always @(negedge clk) begin
      ncyc++;
      if (chk_en && !rst) begin
         checkOutput("retired_track", 32'(retired), 32'(model_retired));
         checkOutput("imem_addr_eq_pc", 32'(bus.imem_addr), 32'(pc));
         checkOutput("busy_halted_excl", 32'(busy && halted), 32'd0);
         if (prev_stall) begin
            checkOutput("hold_valid", 32'(bus.instr_valid), 32'd1);
            checkOutput("hold_instr", 32'(bus.instr), 32'(prev_instr));
            checkOutput("hold_pc", 32'(pc), 32'(prev_pc));
         end
         if (bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("issue_expected", 32'd0, 32'd1);
            end else begin
               e_cur = exp_q.pop_front();
               checkOutput("issue_instr", 32'(bus.instr), 32'(e_cur.ins));
               checkOutput("issue_pc", 32'(pc), 32'(e_cur.addr));
            end
            iss_log.push_back(bus.instr);
            iss_cyc.push_back(ncyc);
            if (model_retired < 65535) model_retired++;
         end
         prev_stall = bus.instr_valid && !bus.instr_ready && !stop;
         prev_instr = bus.instr;
         prev_pc    = pc;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Hard stop if the directed sequence ever stalls indefinitely
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", ncyc);
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios followed by randomized programs
   initial begin
      bit         ok;
      logic [7:0] fpc;
      int         n_iss;
      int         n;
      logic [7:0] sa;

      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      $display("[TB] straight-line program");
      mem[4] = 16'h0102;
      mem[5] = 16'h2081;
      mem[6] = 16'hE000;
      modelRun(8'd4, ok, fpc, n_iss);
      checkOutput("model_sl_issues", 32'(n_iss), 32'd2);
      checkOutput("model_sl_pc", 32'(fpc), 32'd6);
      iss_log.delete();
      iss_cyc.delete();
      startAt(8'd4, 1'b1);
      @(negedge clk);
      checkOutput("sl_fetch_rd", 32'(bus.imem_rd), 32'd1);
      checkOutput("sl_fetch_addr", 32'(bus.imem_addr), 32'd4);
      runUntilHalt(50, 1'b0, n);
      checkOutput("sl_issue_count", 32'(iss_log.size()), 32'd2);
      if (iss_log.size() == 2) begin
         checkOutput("sl_instr0", 32'(iss_log[0]), 32'h0102);
         checkOutput("sl_instr1", 32'(iss_log[1]), 32'h2081);
         checkOutput("sl_first_latency", 32'(iss_cyc[0] - start_ncyc), 32'd3);
         checkOutput("sl_spacing", 32'(iss_cyc[1] - iss_cyc[0]), 32'd3);
      end
      checkOutput("sl_retired", 32'(retired), 32'd2);
      checkOutput("sl_pc", 32'(pc), 32'd6);
      checkOutput("sl_queue", 32'(exp_q.size()), 32'd0);

      $display("[TB] backpressure");
      mem[20] = 16'h4455;
      mem[21] = 16'hE000;
      modelRun(8'd20, ok, fpc, n_iss);
      startAt(8'd20, 1'b0);
      waitValid(10);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_valid", 32'(bus.instr_valid), 32'd1);
         checkOutput("bp_instr", 32'(bus.instr), 32'h4455);
         checkOutput("bp_pc", 32'(pc), 32'd20);
      end
      bus.instr_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_retired", 32'(retired), 32'd1);
      checkOutput("bp_pc_adv", 32'(pc), 32'd21);
      checkOutput("bp_valid_drop", 32'(bus.instr_valid), 32'd0);
      runUntilHalt(50, 1'b0, n);
      checkOutput("bp_queue", 32'(exp_q.size()), 32'd0);

      $display("[TB] opcode 110");
      mem[0]  = 16'hC00A;
      mem[1]  = 16'hE000;
      mem[10] = 16'hE000;
      modelRun(8'd0, ok, fpc, n_iss);
      startAt(8'd0, 1'b1);
      runUntilHalt(50, 1'b0, n);
`ifdef INSTR_SEQ_JUMP_EN
      checkOutput("jmp_model_pc", 32'(fpc), 32'd10);
      checkOutput("jmp_pc", 32'(pc), 32'd10);
      checkOutput("jmp_retired", 32'(retired), 32'd0);
      checkOutput("jmp_cycles", 32'(n), 32'd4);
`else
      checkOutput("nojmp_model_pc", 32'(fpc), 32'd1);
      checkOutput("nojmp_pc", 32'(pc), 32'd1);
      checkOutput("nojmp_retired", 32'(retired), 32'd1);
      checkOutput("nojmp_cycles", 32'(n), 32'd5);
`endif
      checkOutput("jmp_queue", 32'(exp_q.size()), 32'd0);

      $display("[TB] pc wrap");
      mem[255] = 16'h0304;
      mem[0]   = 16'hE000;
      modelRun(8'd255, ok, fpc, n_iss);
      checkOutput("wrap_model_pc", 32'(fpc), 32'd0);
      startAt(8'd255, 1'b1);
      runUntilHalt(50, 1'b0, n);
      checkOutput("wrap_pc", 32'(pc), 32'd0);
      checkOutput("wrap_retired", 32'(retired), 32'd1);

      $display("[TB] stop in WAIT");
      mem[30] = 16'h1234;
      startAt(8'd30, 1'b1);
      @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      checkOutput("stopw_busy", 32'(busy), 32'd0);
      checkOutput("stopw_halted", 32'(halted), 32'd0);
      checkOutput("stopw_retired", 32'(retired), 32'd0);
      checkOutput("stopw_pc", 32'(pc), 32'd30);
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("stopw_idle_valid", 32'(bus.instr_valid), 32'd0);
         checkOutput("stopw_idle_busy", 32'(busy), 32'd0);
      end

      $display("[TB] stop with ready in ISSUE");
      mem[40] = 16'h0A0B;
      mem[41] = 16'hE000;
      modelRun(8'd40, ok, fpc, n_iss);
      startAt(8'd40, 1'b0);
      waitValid(10);
      applyStimulus(1'b0, 8'd40, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 8'd40, 1'b0, 1'b0);
      checkOutput("stopi_busy", 32'(busy), 32'd0);
      checkOutput("stopi_halted", 32'(halted), 32'd0);
      checkOutput("stopi_retired", 32'(retired), 32'd1);
      checkOutput("stopi_pc", 32'(pc), 32'd41);
      checkOutput("stopi_queue", 32'(exp_q.size()), 32'd0);
      applyStimulus(1'b1, 8'd99, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("prio_busy", 32'(busy), 32'd0);
      checkOutput("prio_pc", 32'(pc), 32'd41);

      $display("[TB] reset during ISSUE");
      startAt(8'd40, 1'b0);
      waitValid(10);
      @(posedge clk);
      #3;
      chk_en = 1'b0;
      rst    = 1'b1;
      #1;
      checkAllZero("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      model_retired = 0;
      chk_en = 1'b1;
      modelRun(8'd40, ok, fpc, n_iss);
      startAt(8'd40, 1'b1);
      runUntilHalt(50, 1'b0, n);
      checkOutput("rst_resume_pc", 32'(pc), 32'd41);
      checkOutput("rst_resume_retired", 32'(retired), 32'd1);

      $display("[TB] randomized programs");
      for (int it = 0; it < 10; it++) begin
         ok = 1'b0;
         sa = 8'd0;
         for (int tries = 0; tries < 50 && !ok; tries++) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
            sa = 8'($urandom_range(0, 255));
            modelRun(sa, ok, fpc, n_iss);
         end
         if (ok) begin
            startAt(sa, 1'b1);
            runUntilHalt(3000, 1'b1, n);
            checkOutput("rand_pc", 32'(pc), 32'(fpc));
            checkOutput("rand_retired", 32'(retired), 32'(n_iss));
            checkOutput("rand_queue", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
         end
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
